// File: rtl/light_sequencer_if.sv
// Light bus between the sequencer and its driver: mode/step/hold controls in,
// current colour code and expanded light word out.
interface light_sequencer_if #(parameter int CH_W = 8);
  logic [1:0]        mode;
  logic              button;
  logic              hold;
  logic [2:0]        colour;
  logic [3*CH_W-1:0] light;

  modport master (output mode, button, hold, input colour, light);
  modport slave  (input mode, button, hold, output colour, light);
endinterface

// File: rtl/light_sequencer.sv
// light_sequencer: colour stepping (manual/auto), colour-to-RGB expansion and
// output selection for the board light bus, all in one registered block.
// Optional crossfade is compiled in with `define LIGHT_FADE_EN.
module light_sequencer #(
  parameter int CH_W        = 8,
  parameter int STEP_CYCLES = 100
) (
  input logic              clk,
  input logic              rst,
  light_sequencer_if.slave bus
);
  localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES - 1);

  localparam logic [1:0] M_WHITE  = 2'b00;
  localparam logic [1:0] M_MANUAL = 2'b01;
  localparam logic [1:0] M_AUTO   = 2'b10;

  logic [2:0]           r_colour;
  logic [CW-1:0]        r_cnt;
  logic                 r_btn_q;
  logic [1:0]           r_mode_q;
  logic [2:0][CH_W-1:0] r_light;

  logic                 w_step;
  logic                 w_mchg;
  logic [2:0]           w_next;
  logic [2:0][CH_W-1:0] w_target;

  assign w_step = bus.button & ~r_btn_q;
  assign w_mchg = (bus.mode != r_mode_q);
  // 110 wraps to 001 so 000 and 111 are never produced
  assign w_next = (r_colour == 3'b110) ? 3'b001 : r_colour + 3'd1;

  assign bus.colour = r_colour;
  assign bus.light  = r_light;

  // Target word from mode and the current colour register (R is the top channel)
  always_comb begin
    w_target = '0;
    case (bus.mode)
      M_WHITE:          w_target = '1;
      M_MANUAL, M_AUTO: for (int i = 0; i < 3; i++) w_target[i] = {CH_W{r_colour[i]}};
      default:          w_target = '0;
    endcase
  end

  // Colour sequencing, dwell counter and edge/mode history
  always_ff @(posedge clk) begin
    r_mode_q <= bus.mode;
    if (!rst) begin
      r_colour <= 3'b001;
      r_cnt    <= '0;
      r_btn_q  <= 1'b0;
    end else begin
      r_btn_q <= bus.button;
      case (bus.mode)
        M_MANUAL: begin
          r_cnt <= '0;
          if (!bus.hold && w_step) r_colour <= w_next;
        end
        M_AUTO: begin
          if (bus.hold) begin
            // a mode change still restarts the dwell even while frozen
            if (w_mchg) r_cnt <= '0;
          end else if (w_step || r_cnt == CNT_MAX) begin
            r_colour <= w_next;
            r_cnt    <= '0;
          end else begin
            r_cnt <= w_mchg ? '0 : r_cnt + CW'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Light output: ramp one LSB per edge toward target, or load target directly
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_light <= '0;
    end else begin
`ifdef LIGHT_FADE_EN
      for (int i = 0; i < 3; i++) begin
        if (r_light[i] < w_target[i])      r_light[i] <= r_light[i] + CH_W'(1);
        else if (r_light[i] > w_target[i]) r_light[i] <= r_light[i] - CH_W'(1);
      end
`else
      r_light <= w_target;
`endif
    end
  end
endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench for light_sequencer (CH_W=8, STEP_CYCLES=4) against a
// behavioural model of the colour/light rules. Define LIGHT_FADE_EN for both
// DUT and bench to exercise the crossfade build.
module tb_light_sequencer;
  localparam int CH_W = 8;
  localparam int SC   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  light_sequencer_if #(.CH_W(CH_W)) bus ();
  light_sequencer #(.CH_W(CH_W), .STEP_CYCLES(SC)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  // reference model: colour kept as a number 1..6, channels as integers
  int m_col, m_cnt, m_btn, m_prev;
  int m_ch [3];

  function automatic logic [3*CH_W-1:0] m_light();
    return {m_ch[2][CH_W-1:0], m_ch[1][CH_W-1:0], m_ch[0][CH_W-1:0]};
  endfunction

  task automatic model_edge();
    int tgt [3];
    int md, step, chg;
    md = int'(bus.mode);
    if (!rst) begin
      m_col = 1; m_cnt = 0; m_btn = 0;
      for (int i = 0; i < 3; i++) m_ch[i] = 0;
      m_prev = md;
      return;
    end
    for (int i = 0; i < 3; i++)
      tgt[i] = (md == 0) ? 255 : (md == 3) ? 0 : (((m_col >> i) & 1) * 255);
    step = (bus.button && !m_btn) ? 1 : 0;
    m_btn = int'(bus.button);
    chg = (md != m_prev) ? 1 : 0;
    m_prev = md;
    if (md == 1) begin
      m_cnt = 0;
      if (!bus.hold && step) m_col = m_col % 6 + 1;
    end else if (md == 2) begin
      if (bus.hold) begin
        if (chg) m_cnt = 0;
      end else if (step || m_cnt == SC - 1) begin
        m_col = m_col % 6 + 1; m_cnt = 0;
      end else m_cnt = chg ? 0 : m_cnt + 1;
    end else m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
`ifdef LIGHT_FADE_EN
      if (m_ch[i] < tgt[i]) m_ch[i]++;
      else if (m_ch[i] > tgt[i]) m_ch[i]--;
`else
      m_ch[i] = tgt[i];
`endif
    end
  endtask

  task automatic tick(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic test_reset();
    bus.mode = 2'($urandom); bus.button = 1'b1; bus.hold = 1'($urandom);
    rst = 1'b0;
    tick(2);
    total++; if (bus.light !== 24'h0) begin bad++; $display("FAIL reset_light got=%h want=%h", bus.light, 24'h0); end
    total++; if (bus.colour !== 3'b001) begin bad++; $display("FAIL reset_colour got=%b want=001", bus.colour); end
    rst = 1'b1; bus.mode = 2'b00; bus.button = 1'b0; bus.hold = 1'b0;
    tick(1);
`ifdef LIGHT_FADE_EN
    total++; if (bus.light !== 24'h010101) begin bad++; $display("FAIL white_first got=%h want=010101", bus.light); end
`else
    total++; if (bus.light !== 24'hFFFFFF) begin bad++; $display("FAIL white_first got=%h want=FFFFFF", bus.light); end
`endif
  endtask

  task automatic test_manual();
    logic [2:0] exp_seq [7] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001, 3'b010};
    logic [2:0] c0, cexp;
    bus.mode = 2'b01;
    tick(2);
    for (int k = 0; k < 7; k++) begin
      bus.button = 1'b1; tick(1);
      total++; if (bus.colour !== exp_seq[k]) begin bad++; $display("FAIL manual_step%0d got=%b want=%b", k, bus.colour, exp_seq[k]); end
      bus.button = 1'b0; tick(1);
`ifndef LIGHT_FADE_EN
      if (k == 1) begin
        total++; if (bus.light !== 24'h00FFFF) begin bad++; $display("FAIL manual_light011 got=%h want=00FFFF", bus.light); end
      end
`endif
      total++; if (bus.light !== m_light()) begin bad++; $display("FAIL manual_light%0d got=%h want=%h", k, bus.light, m_light()); end
    end
    c0 = bus.colour;
    cexp = (c0 == 3'b110) ? 3'b001 : c0 + 3'd1;
    bus.button = 1'b1; tick(20); bus.button = 1'b0; tick(2);
    total++; if (bus.colour !== cexp) begin bad++; $display("FAIL manual_held got=%b want=%b", bus.colour, cexp); end
  endtask

  task automatic test_auto();
    int adv;
    logic [2:0] prev, c0;
    bus.mode = 2'b10; tick(1);   // mode-change edge leaves counter at 0
    adv = 0;
    for (int k = 0; k < 12; k++) begin
      prev = bus.colour; tick(1);
      if (bus.colour !== prev) adv++;
      total++; if (bus.colour !== 3'(m_col)) begin bad++; $display("FAIL auto_seq%0d got=%b want=%0d", k, bus.colour, m_col); end
    end
    total++; if (adv != 3) begin bad++; $display("FAIL auto_advances got=%0d want=3", adv); end
    // step event coinciding with dwell expiry: one advance only
    tick(SC - 1);
    c0 = bus.colour;
    bus.button = 1'b1; tick(1); bus.button = 1'b0;
    total++; if (bus.colour !== ((c0 == 3'b110) ? 3'b001 : c0 + 3'd1)) begin bad++; $display("FAIL auto_coincide got=%b from=%b", bus.colour, c0); end
    c0 = bus.colour;
    tick(SC - 1);
    total++; if (bus.colour !== c0) begin bad++; $display("FAIL auto_cnt_cleared got=%b want=%b", bus.colour, c0); end
    tick(1);
    total++; if (bus.colour === c0) begin bad++; $display("FAIL auto_next_adv got=%b want!=%b", bus.colour, c0); end
    c0 = bus.colour;
    bus.hold = 1'b1;
    for (int k = 0; k < 10; k++) begin bus.button = 1'(k & 1); tick(1); end
    bus.button = 1'b0;
    total++; if (bus.colour !== c0) begin bad++; $display("FAIL auto_hold got=%b want=%b", bus.colour, c0); end
    bus.hold = 1'b0; tick(1);
  endtask

  task automatic test_modes();
    logic [2:0] c0;
    tick(2);
    c0 = bus.colour;
    bus.mode = 2'b11; tick(1);
`ifndef LIGHT_FADE_EN
    total++; if (bus.light !== 24'h0) begin bad++; $display("FAIL off_light got=%h want=0", bus.light); end
`endif
    total++; if (bus.light !== m_light()) begin bad++; $display("FAIL off_model got=%h want=%h", bus.light, m_light()); end
    total++; if (bus.colour !== c0) begin bad++; $display("FAIL off_colour got=%b want=%b", bus.colour, c0); end
    tick(3);
    bus.mode = 2'b10; tick(SC);
    total++; if (bus.colour !== c0) begin bad++; $display("FAIL reauto_dwell got=%b want=%b", bus.colour, c0); end
    tick(1);
    total++; if (bus.colour !== 3'(m_col)) begin bad++; $display("FAIL reauto_adv got=%b want=%0d", bus.colour, m_col); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(15) == 0) bus.mode = 2'($urandom);
      bus.button = 1'($urandom_range(2) == 0);
      bus.hold   = 1'($urandom_range(7) == 0);
      rst        = ($urandom_range(199) != 0);
      tick(1);
      total++;
      if (bus.colour !== 3'(m_col) || bus.light !== m_light()) begin
        bad++; $display("FAIL rand%0d colour=%b/%0d light=%h/%h", k, bus.colour, m_col, bus.light, m_light());
      end
    end
    rst = 1'b1; bus.button = 1'b0; bus.hold = 1'b0;
  endtask

`ifdef LIGHT_FADE_EN
  task automatic test_fade();
    bus.mode = 2'b11; tick(260);
    bus.mode = 2'b00; tick(8'h80);
    total++; if (bus.light !== 24'h808080) begin bad++; $display("FAIL fade_up got=%h want=808080", bus.light); end
    bus.mode = 2'b11; tick(1);
    total++; if (bus.light !== 24'h7F7F7F) begin bad++; $display("FAIL fade_redirect got=%h want=7F7F7F", bus.light); end
    tick(5);
    rst = 1'b0; tick(1);
    total++; if (bus.light !== 24'h0) begin bad++; $display("FAIL fade_reset got=%h want=0", bus.light); end
    rst = 1'b1;
  endtask
`endif

  initial begin
    m_col = 1; m_cnt = 0; m_btn = 0; m_prev = 0;
    for (int i = 0; i < 3; i++) m_ch[i] = 0;
    bus.mode = 2'b00; bus.button = 1'b0; bus.hold = 1'b0;
    test_reset();
    test_manual();
    test_auto();
    test_modes();
    test_random();
`ifdef LIGHT_FADE_EN
    test_fade();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
